// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB/BHT branch predictor: 2-bit counter
// encodings, saturating counter steps and PC index/tag slicing.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Slice helpers work on a 64-bit view of the PC; callers truncate the result.
  localparam int unsigned PC_MAX_W = 64;

  function automatic ctr_e ctr_inc(input ctr_e c);
    return (c == CTR_ST) ? CTR_ST : ctr_e'(c + 2'd1);
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_e'(c - 2'd1);
  endfunction

  function automatic logic [PC_MAX_W-1:0] pc_idx(input logic [PC_MAX_W-1:0] pc,
                                                 input int unsigned idx_w);
    return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [PC_MAX_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc,
                                                 input int unsigned idx_w,
                                                 input int unsigned tag_w);
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit counters: combinational lookup at IF,
// training at EX, plus a saturating mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_br,
  input  logic             upd_is_jal,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispred,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  ctr_e             ctr_q   [ENTRIES];
  logic             jal_q   [ENTRIES];
  logic [CNT_W-1:0] cnt_q;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit, upd_en;

  always_comb begin
    l_idx = IDX_W'(pc_idx(PC_MAX_W'(if_pc), IDX_W));
    l_tag = TAG_W'(pc_tag(PC_MAX_W'(if_pc), IDX_W, TAG_W));
    u_idx = IDX_W'(pc_idx(PC_MAX_W'(upd_pc), IDX_W));
    u_tag = TAG_W'(pc_tag(PC_MAX_W'(upd_pc), IDX_W, TAG_W));
    l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    upd_en = upd_valid && (upd_is_br || upd_is_jal);
  end

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_taken  = l_hit && (jal_q[l_idx] || ctr_q[l_idx][1]);
    pred_target = pred_taken ? tgt_q[l_idx] : if_pc + XLEN'(4);
  end

  assign mispred_cnt = cnt_q;

  // Tag, target and jal are left unreset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
      cnt_q <= '0;
    end else begin
      if (upd_en) begin
        if (u_hit) begin
          if (upd_is_jal) begin
            ctr_q[u_idx] <= CTR_ST;
            tgt_q[u_idx] <= upd_target;
          end else begin
            ctr_q[u_idx] <= upd_taken ? ctr_inc(ctr_q[u_idx]) : ctr_dec(ctr_q[u_idx]);
            if (upd_taken) tgt_q[u_idx] <= upd_target;
          end
        end else if (upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= upd_target;
          jal_q[u_idx]   <= upd_is_jal;
          ctr_q[u_idx]   <= upd_is_jal ? CTR_ST : CTR_WT;
        end
      end
      if (upd_valid && upd_mispred && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor (CNT_W=4 build so the
// mispredict counter saturation is reachable quickly).
module tb_branch_predictor;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic             upd_valid, upd_is_br, upd_is_jal, upd_taken, upd_mispred;
  logic [XLEN-1:0]  upd_pc, upd_target;
  logic [CNT_W-1:0] mispred_cnt;

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(64), .TAG_W(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br),
    .upd_is_jal(upd_is_jal), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispred(upd_mispred), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             taken;
    logic [XLEN-1:0]  tgt;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: outputs are stable between input changes, sampled on negedge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (pred_taken !== e.taken) begin
        n_bad++;
        $display("FAIL %s pred_taken got %0b want %0b", e.name, pred_taken, e.taken);
      end
      n_cmp++;
      if (pred_target !== e.tgt) begin
        n_bad++;
        $display("FAIL %s pred_target got %h want %h", e.name, pred_target, e.tgt);
      end
      n_cmp++;
      if (mispred_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL %s mispred_cnt got %0d want %0d", e.name, mispred_cnt, e.cnt);
      end
    end
  end

  // Expectation describes outputs before the upcoming posedge (pre-update state).
  task automatic step(input logic [XLEN-1:0] lpc, input logic uv, input logic ubr,
                      input logic ujal, input logic utk, input logic [XLEN-1:0] upc,
                      input logic [XLEN-1:0] utgt, input logic umis,
                      input logic et, input logic [XLEN-1:0] etgt,
                      input logic [CNT_W-1:0] ecnt, input string nm);
    if_pc = lpc;  upd_valid = uv;  upd_is_br = ubr;  upd_is_jal = ujal;
    upd_taken = utk;  upd_pc = upc;  upd_target = utgt;  upd_mispred = umis;
    sb.push_back('{et, etgt, ecnt, nm});
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [XLEN-1:0] lpc, input logic et,
                      input logic [XLEN-1:0] etgt, input logic [CNT_W-1:0] ecnt,
                      input string nm);
    step(lpc, 0, 0, 0, 0, '0, '0, 0, et, etgt, ecnt, nm);
  endtask

  localparam logic [XLEN-1:0] PA  = 64'h8000_0010;
  localparam logic [XLEN-1:0] PAL = 64'h8000_0110;

  initial begin
    rst = 1'b1;  if_pc = '0;  upd_valid = 0;  upd_is_br = 0;  upd_is_jal = 0;
    upd_taken = 0;  upd_pc = '0;  upd_target = '0;  upd_mispred = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    look(64'h8000_0000, 0, 64'h8000_0004, 0, "reset_lookup");
    // allocate taken branch; same-cycle lookup still misses
    step(PA, 1, 1, 0, 1, PA, 64'h8000_0100, 1, 0, 64'h8000_0014, 0, "alloc_same_cycle");
    step(PA, 1, 1, 0, 0, PA, '0, 1, 1, 64'h8000_0100, 1, "alloc_hit");
    step(PA, 1, 1, 0, 0, PA, '0, 0, 0, 64'h8000_0014, 2, "nt1_ctr01");
    step(PA, 1, 1, 0, 0, PA, '0, 0, 0, 64'h8000_0014, 2, "nt2_ctr00");
    step(PA, 1, 1, 0, 1, PA, 64'h8000_0100, 0, 0, 64'h8000_0014, 2, "nt3_sat00");
    step(PA, 1, 1, 0, 1, PA, 64'h8000_0100, 0, 0, 64'h8000_0014, 2, "tk1_ctr01");
    look(PA, 1, 64'h8000_0100, 2, "tk2_ctr10");

    // not-taken miss and flagless update must not allocate
    step(64'h8000_0020, 1, 1, 0, 0, 64'h8000_0020, 64'h8000_0200, 0,
         0, 64'h8000_0024, 2, "nt_miss_same");
    look(64'h8000_0020, 0, 64'h8000_0024, 2, "nt_miss_after");
    step(64'h8000_0020, 1, 0, 0, 1, 64'h8000_0020, 64'h8000_0300, 0,
         0, 64'h8000_0024, 2, "noflag_same");
    look(64'h8000_0020, 0, 64'h8000_0024, 2, "noflag_after");

    // alias replaces entry 4
    step(PAL, 1, 0, 1, 1, PAL, 64'h8000_2000, 0, 0, 64'h8000_0114, 2, "alias_alloc");
    look(PA, 0, 64'h8000_0014, 2, "alias_orig_miss");
    step(PAL, 1, 1, 0, 0, PAL, '0, 0, 1, 64'h8000_2000, 2, "jal_nt1");
    step(PAL, 1, 1, 0, 0, PAL, '0, 0, 1, 64'h8000_2000, 2, "jal_nt2");
    step(PAL, 1, 1, 0, 0, PAL, '0, 0, 1, 64'h8000_2000, 2, "jal_nt3");
    look(PAL, 1, 64'h8000_2000, 2, "jal_still_taken");

    // both flags set behaves as JAL
    step(64'h8000_0040, 1, 1, 1, 1, 64'h8000_0040, 64'h8000_0500, 0,
         0, 64'h8000_0044, 2, "both_alloc");
    step(64'h8000_0040, 1, 1, 0, 0, 64'h8000_0040, '0, 0,
         1, 64'h8000_0500, 2, "both_nt");
    look(64'h8000_0040, 1, 64'h8000_0500, 2, "both_still_taken");

    step(64'h8000_0080, 1, 1, 0, 1, 64'h8000_0080, 64'h8000_0800, 0,
         0, 64'h8000_0084, 2, "same_cycle_old");
    look(64'h8000_0080, 1, 64'h8000_0800, 2, "same_cycle_new");
    look(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 2, "pc_wrap");

    for (int i = 0; i < 19; i++) begin
      step(64'h8000_0000, 1, 0, 0, 0, '0, '0, 1, 0, 64'h8000_0004,
           CNT_W'((2 + i > 15) ? 15 : 2 + i), "mispred_pulse");
    end
    look(64'h8000_0000, 0, 64'h8000_0004, 15, "mispred_sat");

    // reset wins over a concurrent update and mispredict
    rst = 1'b1;  upd_valid = 1;  upd_is_br = 1;  upd_is_jal = 0;  upd_taken = 1;
    upd_pc = PA;  upd_target = 64'h8000_0900;  upd_mispred = 1;  if_pc = PA;
    @(posedge clk);
    #1 rst = 1'b0;
    look(PA, 0, 64'h8000_0014, 0, "rst_discard_upd");
    look(PAL, 0, 64'h8000_0114, 0, "rst_clear_alias");
    look(64'h8000_0080, 0, 64'h8000_0084, 0, "rst_clear_entry");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
